vga_cmd_controller: RTL and testbench
=====================================

Name: vga_cmd_controller

Overview:
- Command controller between the UART receive path and the VGA test-pattern datapath.
- Parses 1- and 2-byte command packets from received bytes and holds shadow copies of pattern and foreground colour.
- Commits the shadow values to the video-facing registers only on a vblank rising edge, so the display never tears mid-frame.
- Sends one-byte status responses to the UART transmitter; its TX outputs replace the FIFO echo path.

Parameters:
- TIMEOUT_CYCLES, 2500000, max cycles between command byte and argument byte (100 ms at 25 MHz).
- RESET_PATTERN, 4'h0, pattern value after reset.
- RESET_COLOR, 9'h1FF, foreground RGB333 value after reset.
- COMMIT_ON_VBLANK, 1, 1 = commit on vblank rising edge; 0 = commit on the cycle after the argument arrives.

Ports:
- i_clk  in  1  system clock (25 MHz pixel clock)
- i_rst  in  1  reset
- i_rx_byte  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_byte valid
- i_vblank  in  1  vertical blanking level from the sync generator
- i_tx_active  in  1  transmitter busy
- i_tx_done  in  1  transmitter one-cycle done strobe
- o_tx_byte  out  8  response byte
- o_tx_dv  out  1  one-cycle launch strobe to the transmitter
- o_pattern  out  4  committed pattern select
- o_fg_color  out  9  committed colour {R[2:0],G[2:0],B[2:0]}
- o_busy  out  1  high in S_ARG or S_WAIT_VB
- o_resp_drop  out  1  one-cycle pulse when a queued response is overwritten

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_pattern=RESET_PATTERN, o_fg_color=RESET_COLOR, o_tx_byte=0, o_tx_dv=0, o_busy=0, o_resp_drop=0. Parser goes to S_IDLE; TX goes to T_IDLE with no response pending; timer=0; vblank delay reg=1, so there is no false edge after reset.
- Reset mid-packet or mid-transmit: abandon everything; the shadow value is not committed.
- Commands:
  - 0x50 'P' + arg: pattern = arg[3:0].
  - 0x46 'F' + arg: colour = {arg[7:5], arg[4:2], arg[1:0], arg[1]}.
  - 0x3F '?': no argument; response is {4'h0, o_pattern}.
- Parser FSM:
  - S_IDLE, on i_rx_valid:
    - 'P' or 'F': latch opcode, timer=0, go to S_ARG.
    - '?': queue response, stay.
    - anything else: queue 0x45 'E', stay.
  - S_ARG:
    - timer increments each cycle.
    - i_rx_valid: store arg in shadow, go to S_WAIT_VB.
    - timer==TIMEOUT_CYCLES-1 without valid: queue 'E', go to S_IDLE.
    - If valid and timeout occur in the same cycle, valid wins.
  - S_WAIT_VB:
    - Commit on vblank_rise = i_vblank & ~vblank_d. The rise must occur in a cycle after entering the state.
    - On commit: update o_pattern or o_fg_color, queue 0x4B 'K', go to S_IDLE.
    - COMMIT_ON_VBLANK=0: commit on the first cycle in this state.
    - Bytes received here are discarded; queue 'E' for each.
- Commit latency:
  - Register update is visible the cycle after vblank_rise.
  - The 'K' response is queued in that same cycle.
- Response queue: single entry (resp_byte, resp_pend).
  - Queuing while resp_pend=1 overwrites the byte and pulses o_resp_drop.
  - Queuing in the same cycle the TX FSM launches the old byte is not a drop: launch takes the old byte, the new byte becomes pending.
- TX FSM:
  - T_IDLE: when resp_pend & ~i_tx_active, drive o_tx_byte=resp_byte and o_tx_dv=1 for exactly one cycle, clear resp_pend, go to T_WAIT.
  - T_WAIT: wait for i_tx_done, then go to T_IDLE. There is no second launch before done.
  - o_tx_byte holds its value until the next launch.
- Timer width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Shared package (vga_cmd_pkg): opcode constants CMD_PATTERN 8'h50, CMD_COLOR 8'h46, CMD_QUERY 8'h3F; response constants RSP_OK 8'h4B, RSP_ERR 8'h45; parser and TX state encodings.
- One natural sub-module, resp_tx_queue: the single-entry queue plus TX FSM, with ports for queue write, drop pulse and transmitter handshake.

Test Plan:
- Reset, then idle 1000 cycles -> o_pattern=0, o_fg_color=9'h1FF, o_tx_dv never asserted.
- 0x50,0x07 with vblank low; raise vblank 500 cycles later -> o_pattern=7 one cycle after the rise (not before); o_tx_byte=0x4B, one o_tx_dv pulse.
- 0x46,0xE3 with COMMIT_ON_VBLANK=1 -> at vblank rise o_fg_color=9'b111_000_111; response 'K'.
- 0x50 then no byte, TIMEOUT_CYCLES=100 -> 'E' at cycle 100, o_busy falls, o_pattern unchanged; a later 0x07 yields 'E', not a commit.
- 0x3F with pattern 5 while i_tx_active held high, then 0x12 before i_tx_active drops -> o_resp_drop pulses once; after the active release exactly one byte, 0x45, is sent.
- i_rst asserted in S_WAIT_VB after arg 0x09 -> no commit, o_pattern=RESET_PATTERN, no 'K' sent.

Source files
------------

// File: rtl/vga_cmd_controller_pkg.sv
// Shared types and constants for the VGA command controller.
// Opcodes, response bytes, FSM encodings and a colour helper.
package vga_cmd_pkg;

  localparam logic [7:0] CMD_PATTERN = 8'h50;
  localparam logic [7:0] CMD_COLOR   = 8'h46;
  localparam logic [7:0] CMD_QUERY   = 8'h3F;
  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_ERR     = 8'h45;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARG,
    S_WAIT_VB
  } parse_state_t;

  typedef enum logic {
    T_IDLE,
    T_WAIT
  } tx_state_t;

  // Widen an 8-bit argument to RGB333 by repeating the top blue bit.
  function automatic logic [8:0] rgb333(input logic [7:0] a);
    return {a[7:5], a[4:2], a[1:0], a[1]};
  endfunction

endpackage

// File: rtl/vga_cmd_controller_if.sv
// UART/video-facing bundle of the command controller.
// The slave side is the controller, the master side its environment.
interface vga_cmd_controller_if;

  logic [7:0] i_rx_byte;
  logic       i_rx_valid;
  logic       i_vblank;
  logic       i_tx_active;
  logic       i_tx_done;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv;
  logic [3:0] o_pattern;
  logic [8:0] o_fg_color;
  logic       o_busy;
  logic       o_resp_drop;

  modport slave (
    input  i_rx_byte, i_rx_valid, i_vblank,
    input  i_tx_active, i_tx_done,
    output o_tx_byte, o_tx_dv, o_pattern,
    output o_fg_color, o_busy, o_resp_drop
  );

  modport master (
    output i_rx_byte, i_rx_valid, i_vblank,
    output i_tx_active, i_tx_done,
    input  o_tx_byte, o_tx_dv, o_pattern,
    input  o_fg_color, o_busy, o_resp_drop
  );

endinterface

// File: rtl/vga_cmd_controller_resp_tx_queue.sv
// Single-entry response slot feeding the UART transmitter.
// A newer response overwrites an unsent one and flags the drop.
module resp_tx_queue
  import vga_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic [7:0] tx_byte,
  output logic       tx_dv,
  output logic       drop
);

  tx_state_t  tstate;
  logic [7:0] rbyte;
  logic       pend;
  logic       launch;

  assign launch = (tstate == T_IDLE) & pend & ~tx_active;

  // Queue slot plus launch/wait-for-done transmit sequencing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tstate  <= T_IDLE;
      rbyte   <= '0;
      pend    <= 1'b0;
      tx_byte <= '0;
      tx_dv   <= 1'b0;
      drop    <= 1'b0;
    end else begin
      tx_dv <= 1'b0;
      drop  <= 1'b0;
      if (wr) begin
        rbyte <= wr_data;
        pend  <= 1'b1;
        drop  <= pend & ~launch;
      end else if (launch) begin
        pend <= 1'b0;
      end
      case (tstate)
        T_IDLE: begin
          if (launch) begin
            tx_byte <= rbyte;
            tx_dv   <= 1'b1;
            tstate  <= T_WAIT;
          end
        end
        T_WAIT: begin
          if (tx_done) tstate <= T_IDLE;
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_cmd_controller.sv
// Command parser with shadow registers committed on vblank.
// Replies go out one byte at a time through resp_tx_queue.
module vga_cmd_controller
  import vga_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES   = 2500000,
  parameter logic [3:0] RESET_PATTERN    = 4'h0,
  parameter logic [8:0] RESET_COLOR      = 9'h1FF,
  parameter bit         COMMIT_ON_VBLANK = 1'b1
) (
  input logic i_clk,
  input logic i_rst,
  vga_cmd_controller_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  parse_state_t  state;
  logic [7:0]    op_q;
  logic [7:0]    arg_q;
  logic [TW-1:0] timer;
  logic          vb_d;
  logic [3:0]    pat_q;
  logic [8:0]    fg_q;
  logic          busy_q;

  logic       vb_rise;
  logic       commit;
  logic       has_arg;
  logic       is_query;
  logic       q_wr;
  logic [7:0] q_data;

  assign vb_rise  = bus.i_vblank & ~vb_d;
  assign commit   = (state == S_WAIT_VB) &
                    (COMMIT_ON_VBLANK ? vb_rise : 1'b1);
  assign has_arg  = (bus.i_rx_byte == CMD_PATTERN) |
                    (bus.i_rx_byte == CMD_COLOR);
  assign is_query = bus.i_rx_byte == CMD_QUERY;

  // Pick the response byte queued this cycle, if any.
  always_comb begin
    q_wr   = 1'b0;
    q_data = RSP_ERR;
    case (state)
      S_IDLE: begin
        if (bus.i_rx_valid && !has_arg) begin
          q_wr   = 1'b1;
          q_data = is_query ? {4'h0, pat_q} : RSP_ERR;
        end
      end
      S_ARG: begin
        if (!bus.i_rx_valid && timer == T_LAST)
          q_wr = 1'b1;
      end
      S_WAIT_VB: begin
        unique case (1'b1)
          commit: begin
            q_wr   = 1'b1;
            q_data = RSP_OK;
          end
          bus.i_rx_valid: q_wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Delay vblank by one cycle; reset high to hide a false edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) vb_d <= 1'b1;
    else       vb_d <= bus.i_vblank;
  end

  // Parser FSM, shadow argument and committed video registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      arg_q  <= '0;
      timer  <= '0;
      pat_q  <= RESET_PATTERN;
      fg_q   <= RESET_COLOR;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_rx_valid && has_arg) begin
            op_q   <= bus.i_rx_byte;
            timer  <= '0;
            state  <= S_ARG;
            busy_q <= 1'b1;
          end
        end
        S_ARG: begin
          if (bus.i_rx_valid) begin
            arg_q <= bus.i_rx_byte;
            state <= S_WAIT_VB;
          end else if (timer == T_LAST) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_VB: begin
          if (commit) begin
            if (op_q == CMD_PATTERN) pat_q <= arg_q[3:0];
            else                     fg_q  <= rgb333(arg_q);
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  resp_tx_queue u_txq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .wr        (q_wr),
    .wr_data   (q_data),
    .tx_active (bus.i_tx_active),
    .tx_done   (bus.i_tx_done),
    .tx_byte   (bus.o_tx_byte),
    .tx_dv     (bus.o_tx_dv),
    .drop      (bus.o_resp_drop)
  );

  assign bus.o_pattern  = pat_q;
  assign bus.o_fg_color = fg_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_vga_cmd_controller.sv
// Scoreboard bench for vga_cmd_controller.
// Expected TX bytes are queued at stimulus and popped on o_tx_dv.
module tb_vga_cmd_controller;

  logic i_clk = 1'b0;
  logic i_rst;
  logic hold_active;
  logic model_busy;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0;
  int drop_cnt = 0;
  int d0;
  int r0;

  logic [7:0] exp_q[$];

  vga_cmd_controller_if bus ();

  assign bus.i_tx_active = hold_active | model_busy;

  vga_cmd_controller #(
    .TIMEOUT_CYCLES   (100),
    .RESET_PATTERN    (4'h0),
    .RESET_COLOR      (9'h1FF),
    .COMMIT_ON_VBLANK (1'b1)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #20 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_rx_byte  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge i_clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Count strobes and score each launched byte.
  initial begin
    forever begin
      @(negedge i_clk);
      if (bus.o_resp_drop) drop_cnt++;
      if (bus.o_tx_dv) begin
        dv_cnt++;
        if (exp_q.size() == 0)
          chk("tx_spurious", 0, 1);
        else
          chk("tx_byte", bus.o_tx_byte, exp_q.pop_front());
      end
    end
  end

  // Transmitter model: busy for a few cycles, then done.
  initial begin
    model_busy    = 1'b0;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (bus.o_tx_dv) begin
        model_busy = 1'b1;
        repeat (4) @(negedge i_clk);
        bus.i_tx_done = 1'b1;
        model_busy    = 1'b0;
        @(negedge i_clk);
        bus.i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst          = 1'b1;
    hold_active    = 1'b0;
    bus.i_rx_byte  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_vblank   = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("rst_pattern", bus.o_pattern, 4'h0);
    chk("rst_color", bus.o_fg_color, 9'h1FF);
    chk("rst_txbyte", bus.o_tx_byte, 8'h00);
    chk("rst_dv", bus.o_tx_dv, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_drop", bus.o_resp_drop, 1'b0);
    i_rst = 1'b0;

    d0 = dv_cnt;
    repeat (1000) @(negedge i_clk);
    chk("idle_dv", dv_cnt - d0, 0);
    chk("idle_pattern", bus.o_pattern, 4'h0);
    chk("idle_color", bus.o_fg_color, 9'h1FF);

    d0 = dv_cnt;
    send(8'h50);
    chk("p_busy", bus.o_busy, 1'b1);
    send(8'h07);
    repeat (500) @(negedge i_clk);
    chk("p_pre_vb", bus.o_pattern, 4'h0);
    exp_q.push_back(8'h4B);
    bus.i_vblank = 1'b1;
    @(negedge i_clk);
    chk("p_commit", bus.o_pattern, 4'h7);
    chk("p_idle", bus.o_busy, 1'b0);
    drain();
    chk("p_txbyte", bus.o_tx_byte, 8'h4B);
    chk("p_dv_once", dv_cnt - d0, 1);
    bus.i_vblank = 1'b0;

    exp_q.push_back(8'h07);
    send(8'h3F);
    drain();

    send(8'h46);
    send(8'hE3);
    repeat (20) @(negedge i_clk);
    chk("f_pre_vb", bus.o_fg_color, 9'h1FF);
    exp_q.push_back(8'h4B);
    bus.i_vblank = 1'b1;
    @(negedge i_clk);
    chk("f_commit", bus.o_fg_color, 9'b111_000_111);
    drain();
    bus.i_vblank = 1'b0;

    exp_q.push_back(8'h45);
    send(8'h50);
    repeat (99) @(negedge i_clk);
    chk("to_busy_hi", bus.o_busy, 1'b1);
    @(negedge i_clk);
    chk("to_busy_lo", bus.o_busy, 1'b0);
    drain();
    chk("to_pattern", bus.o_pattern, 4'h7);
    exp_q.push_back(8'h45);
    send(8'h07);
    repeat (20) @(negedge i_clk);
    chk("late_busy", bus.o_busy, 1'b0);
    drain();
    chk("late_pattern", bus.o_pattern, 4'h7);

    exp_q.push_back(8'h4B);
    send(8'h50);
    send(8'h05);
    repeat (5) @(negedge i_clk);
    bus.i_vblank = 1'b1;
    @(negedge i_clk);
    bus.i_vblank = 1'b0;
    drain();
    chk("p5_pattern", bus.o_pattern, 4'h5);
    repeat (10) @(negedge i_clk);

    hold_active = 1'b1;
    d0 = dv_cnt;
    r0 = drop_cnt;
    send(8'h3F);
    repeat (5) @(negedge i_clk);
    chk("held_no_tx", dv_cnt - d0, 0);
    exp_q.push_back(8'h45);
    send(8'h12);
    repeat (5) @(negedge i_clk);
    chk("drop_once", drop_cnt - r0, 1);
    hold_active = 1'b0;
    drain();
    repeat (30) @(negedge i_clk);
    chk("drop_one_tx", dv_cnt - d0, 1);
    chk("drop_txbyte", bus.o_tx_byte, 8'h45);

    d0 = dv_cnt;
    send(8'h50);
    send(8'h09);
    chk("rst_wait_busy", bus.o_busy, 1'b1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_mid_busy", bus.o_busy, 1'b0);
    chk("rst_mid_pat", bus.o_pattern, 4'h0);
    bus.i_vblank = 1'b1;
    repeat (5) @(negedge i_clk);
    bus.i_vblank = 1'b0;
    repeat (50) @(negedge i_clk);
    chk("rst_no_commit", bus.o_pattern, 4'h0);
    chk("rst_no_k", dv_cnt - d0, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
